// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative RV32M multiply/divide unit:
//   - funct3 encodings of the M-extension operations
//   - FSM state encoding
//   - number of radix-2 iterations per operation
// -----------------------------------------------------------------------------
package muldiv_pkg;

    localparam int ITERATIONS = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Divide family is identified by funct3[2].
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide unit with a fixed latency: start sampled at
// edge N gives done=1 in the cycle after edge N+33, for every op and operand.
// Multiply is radix-2 shift-add on magnitudes, divide is radix-2 restoring
// division on magnitudes; signs are applied in the cycle after the last
// iteration, when the result is written.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin an operation (accepted only in IDLE)
//   kill     in   synchronous abort, beats start and iteration
//   funct3   in   M-extension operation select
//   rs1_val  in   first operand
//   rs2_val  in   second operand
//   rd_in    in   destination register tag
//   busy     out  operation in flight (CALC)
//   done     out  one-cycle pulse, result/rd_out valid (DONE)
//   result   out  write-back data, held until the next done
//   rd_out   out  destination tag, held until the next done
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    state_e            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [4:0]        rd_q, rd_d;

    // Operation context latched on an accepted start
    logic [2:0]        op_q;
    logic [4:0]        tag_q;
    logic              neg_q;
    logic              divz_q;
    logic [XLEN-1:0]   opnd_q;       // multiplicand (mul) or divisor (div)
    logic [2*XLEN-1:0] acc_q;        // {hi, lo} product or {remainder, quotient}

    logic              accept;
    logic              iterate;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              neg_start;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_part;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo, rem;
    logic [XLEN-1:0]   final_res;

    assign accept  = (state_q == ST_IDLE) && start && !kill;
    // Count value ITERATIONS is the finalize cycle: no iteration is performed.
    assign iterate = (state_q == ST_CALC) && (cnt_q < 6'(ITERATIONS));

    // Operand signs only count for the signed operand positions of each op.
    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (funct3)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                sign_a = rs1_val[XLEN-1];
                sign_b = rs2_val[XLEN-1];
            end
            F3_MULHSU: sign_a = rs1_val[XLEN-1];
            default: ;
        endcase
    end

    assign mag_a     = sign_a ? (~rs1_val + 1'b1) : rs1_val;
    assign mag_b     = sign_b ? (~rs2_val + 1'b1) : rs2_val;
    // Remainder takes the dividend's sign; everything else the XOR of signs.
    assign neg_start = (funct3 == F3_REM) ? sign_a : (sign_a ^ sign_b);

    // ---- iteration datapath ----
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    assign div_part = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = div_part - {1'b0, opnd_q};
    assign div_next = div_diff[XLEN]
                    ? {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q   <= funct3;
            tag_q  <= rd_in;
            neg_q  <= neg_start;
            divz_q <= (rs2_val == '0);
            opnd_q <= is_div_op(funct3) ? mag_b : mag_a;
            acc_q  <= is_div_op(funct3) ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
        end else if (iterate) begin
            acc_q  <= is_div_op(op_q) ? div_next : mul_next;
        end
    end

    // ---- sign fix-up ----
    // Restoring division by zero naturally yields an all-ones quotient and the
    // dividend as remainder; only the quotient negation must be suppressed.
    assign prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quo      = acc_q[XLEN-1:0];
    assign rem      = acc_q[2*XLEN-1:XLEN];

    always_comb begin
        final_res = '0;
        case (op_q)
            F3_MUL:                        final_res = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  final_res = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               final_res = (neg_q && !divz_q) ? (~quo + 1'b1) : quo;
            default:                       final_res = neg_q ? (~rem + 1'b1) : rem;
        endcase
    end

    // ---- control FSM ----
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rd_d     = rd_q;
        if (kill) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_CALC;
                        cnt_d   = '0;
                    end
                end
                ST_CALC: begin
                    if (cnt_q == 6'(ITERATIONS)) begin
                        state_d  = ST_DONE;
                        cnt_d    = '0;
                        result_d = final_res;
                        rd_d     = tag_q;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign busy   = (state_q == ST_CALC);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign rd_out = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Table-driven bench for muldiv_unit with a result scoreboard, plus hand
// sequences for kill, ignored starts and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    muldiv_unit #(.XLEN(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .kill    (kill),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_in   (rd_in),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .rd_out  (rd_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model built on native 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            F3_MUL:    begin p = ua * ub; return p[31:0]; end
            F3_MULH:   begin p = sa * sb; return p[63:32]; end
            F3_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
            F3_MULHU:  begin p = ua * ub; return p[63:32]; end
            F3_DIV:    begin p = sa / sb; return p[31:0]; end
            F3_DIVU:   begin p = ua / ub; return p[31:0]; end
            F3_REM:    begin p = sa % sb; return p[31:0]; end
            default:   begin p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("rd_out", 32'(rd_out), 32'(e.rd));
            end
        end
    end

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input bit mid_start);
        int n;
        bit seen;
        sb_q.push_back('{res: exp, rd: rd});
        @(negedge clk);
        funct3 = f; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        funct3  = 3'($urandom);
        rs1_val = $urandom;
        rs2_val = $urandom;
        rd_in   = 5'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            if (mid_start && n == 5) start = 1'b1;
            if (n == 6) start = 1'b0;
            @(posedge clk); #1;
            n++;
            if (done) seen = 1;
        end
        start = 1'b0;
        // done in cycle 34 counting the start-edge cycle as cycle 1
        check("latency_edges", 32'(n), 32'd33);
        start = 1'b1;  // offered during DONE, must be ignored
        @(posedge clk); #1;
        start = 1'b0;
        check("start_in_done_ignored", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("result_hold", result, exp);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0;
        funct3 = '0; rs1_val = '0; rs2_val = '0; rd_in = '0;
        #3;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", result,      32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{F3_MUL,    32'd7,          32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB});
        vecs.push_back('{F3_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE});
        vecs.push_back('{F3_MULH,   32'hFFFFFFFF,   32'hFFFFFFFF, 5'd2,  32'h00000000});
        vecs.push_back('{F3_MULHSU, 32'hFFFFFFFF,   32'h00000002, 5'd3,  32'hFFFFFFFF});
        vecs.push_back('{F3_DIV,    32'hFFFFFFF9,   32'd2,        5'd4,  32'hFFFFFFFD});
        vecs.push_back('{F3_REM,    32'hFFFFFFF9,   32'd2,        5'd6,  32'hFFFFFFFF});
        vecs.push_back('{F3_DIVU,   32'd100,        32'd7,        5'd7,  32'd14});
        vecs.push_back('{F3_REMU,   32'd100,        32'd7,        5'd8,  32'd2});
        vecs.push_back('{F3_DIV,    32'd100,        32'd0,        5'd9,  32'hFFFFFFFF});
        vecs.push_back('{F3_REM,    32'd100,        32'd0,        5'd10, 32'd100});
        vecs.push_back('{F3_DIV,    32'h80000000,   32'hFFFFFFFF, 5'd11, 32'h80000000});
        vecs.push_back('{F3_REM,    32'h80000000,   32'hFFFFFFFF, 5'd12, 32'h00000000});
        vecs.push_back('{F3_DIVU,   32'd100,        32'd0,        5'd13, 32'hFFFFFFFF});
        vecs.push_back('{F3_REMU,   32'h80000005,   32'd0,        5'd14, 32'h80000005});
        vecs.push_back('{F3_DIV,    32'hFFFFFF9C,   32'd0,        5'd15, 32'hFFFFFFFF});
        vecs.push_back('{F3_REM,    32'hFFFFFF9C,   32'd0,        5'd16, 32'hFFFFFF9C});
        vecs.push_back('{F3_MULHU,  32'h00010000,   32'h00010000, 5'd17, 32'h00000001});
        vecs.push_back('{F3_MULH,   32'h80000000,   32'h80000000, 5'd18, 32'h40000000});
        vecs.push_back('{F3_MULHSU, 32'h80000000,   32'h80000000, 5'd19, 32'hC0000000});
        vecs.push_back('{F3_MUL,    32'hFFFFFFFF,   32'hFFFFFFFF, 5'd20, 32'h00000001});
        vecs.push_back('{F3_DIV,    32'd20,         32'hFFFFFFFA, 5'd21, 32'hFFFFFFFD});
        vecs.push_back('{F3_REM,    32'd20,         32'hFFFFFFFA, 5'd22, 32'h00000002});
        vecs.push_back('{F3_DIV,    32'hFFFFFFEC,   32'hFFFFFFFA, 5'd23, 32'h00000003});
        vecs.push_back('{F3_REM,    32'hFFFFFFEC,   32'hFFFFFFFA, 5'd24, 32'hFFFFFFFE});
        vecs.push_back('{F3_DIVU,   32'hFFFFFFFF,   32'd1,        5'd31, 32'hFFFFFFFF});

        foreach (vecs[i])
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, 1'b0);

        // Random operands against the native-arithmetic model (nonzero divisor).
        for (int i = 0; i < 8; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom);
            a = $urandom;
            b = $urandom | 32'h1;
            run_op(f, a, b, 5'($urandom), model(f, a, b), 1'b0);
        end

        // Kill in the 10th CALC cycle: back to IDLE on the next edge, no done.
        @(negedge clk);
        funct3 = F3_DIVU; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill_to_idle", 32'(busy), 32'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("no_done_after_kill", 32'(ndone), 32'd0);

        // Kill together with start in IDLE does not launch.
        @(negedge clk);
        funct3 = F3_MUL; rs1_val = 32'd3; rs2_val = 32'd3; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("kill_blocks_start", 32'(busy), 32'd0);

        // Second start mid-CALC is ignored; first result unchanged.
        run_op(F3_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 1'b1);

        // Asynchronous reset between edges in mid-CALC.
        @(negedge clk);
        funct3 = F3_REM; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy",   32'(busy),   32'd0);
        check("async_rst_done",   32'(done),   32'd0);
        check("async_rst_result", result,      32'd0);
        check("async_rst_rd_out", 32'(rd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(F3_REMU, 32'd100, 32'd7, 5'd27, 32'd2, 1'b0);

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
